// File: rtl/wdog.sv
// Millisecond watchdog: armed and kicked by a bus write, counts down on ms_tick,
// and emits a one-cycle trig pulse plus a sticky expired flag when it runs out.
module wdog #(
    parameter int cnt_width = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stb,
    input  logic        we,
    input  logic [31:0] data_in,
    input  logic        ms_tick,
    output logic [31:0] data_out,
    output logic        trig,
    output logic        ack
);

    localparam logic [1:0] ST_OFF = 2'd0;
    localparam logic [1:0] ST_RUN = 2'd1;
    localparam logic [1:0] ST_EXP = 2'd2;

    logic [1:0]           state;
    logic [cnt_width-1:0] timeout;
    logic [cnt_width-1:0] count;
    logic [cnt_width-1:0] wr_val;
    logic                 expired;
    logic                 wr;
    logic                 rd;
    logic                 unused_bits;

    assign ack    = stb;
    assign wr     = stb & we;
    assign rd     = stb & ~we;
    assign wr_val = data_in[cnt_width-1:0];

    // timeout is kept as the armed value but is not visible on the bus.
    assign unused_bits = ^{data_in[31:cnt_width], timeout};

    // A write always wins over a coincident tick, so kicking on the last tick avoids expiry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_OFF;
            timeout <= '0;
            count   <= '0;
            expired <= 1'b0;
            trig    <= 1'b0;
        end else begin
            trig <= 1'b0;
            if (wr) begin
                timeout <= wr_val;
                count   <= wr_val;
                expired <= 1'b0;
                state   <= (wr_val == '0) ? ST_OFF : ST_RUN;
            end else begin
                case (state)
                    ST_RUN: begin
                        if (ms_tick) begin
                            if (count > cnt_width'(1)) begin
                                count <= count - cnt_width'(1);
                            end else if (count == cnt_width'(1)) begin
                                count   <= '0;
                                state   <= ST_EXP;
                                expired <= 1'b1;
                                trig    <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        data_out = '0;
        if (rd) begin
            data_out[cnt_width-1:0] = count;
            data_out[cnt_width]     = (state == ST_RUN);
            data_out[cnt_width+1]   = expired;
        end
    end

endmodule
